// File: rtl/approx_mult_pipe.sv
// approx_mult_pipe: 3-stage unsigned multiplier built from 4x4 tiles; each
// tile is exact or OR-compressed approximate, selected per transaction.
//   clk, rst_n              clock, asynchronous active-low reset
//   in_valid/in_ready       operand handshake (in_ready = ~stall, combinational)
//   in_a, in_b, in_apx      operands and approximate-mode flag
//   out_valid/out_ready     result handshake
//   out_p                   product, 2*WIDTH bits
//   stat_clr                synchronous clear of the error statistics
//   err_cnt, err_sum        saturating count / sum of (exact - result)
// Define APPROX_MULT_ERR_STAT_EN to build the error statistics; otherwise
// err_cnt and err_sum are tied to zero and stat_clr is ignored.
module approx_mult_pipe #(
    parameter int WIDTH     = 8,
    parameter int APX_COLS  = 2,
    parameter int APX_TILES = 1
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [WIDTH-1:0]     in_a,
    input  logic [WIDTH-1:0]     in_b,
    input  logic                 in_apx,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [2*WIDTH-1:0]   out_p,
    input  logic                 stat_clr,
    output logic [31:0]          err_cnt,
    output logic [2*WIDTH+15:0]  err_sum
);
    localparam int N  = WIDTH / 4;
    localparam int PW = 2 * WIDTH;

    logic             stall;
    logic             v1, v2, apx1;
    logic [WIDTH-1:0] a1, b1;
    logic [7:0]       tp [N*N];
    logic [7:0]       t2 [N*N];
    logic [PW-1:0]    sum;

    assign stall    = out_valid & ~out_ready;
    assign in_ready = ~stall;

    // Approximate columns are OR-reduced into lo; the remaining columns are
    // summed exactly into hi, which never carries into the low columns.
    function automatic logic [7:0] tile(input logic [3:0] a, input logic [3:0] b, input logic apx);
        logic [7:0] lo, hi;
        lo = '0;
        hi = '0;
        for (int i = 0; i < 4; i++)
            for (int j = 0; j < 4; j++)
                if (apx && (i + j < APX_COLS)) lo[i+j] = lo[i+j] | (a[i] & b[j]);
                else hi = hi + (8'(a[i] & b[j]) << (i + j));
        return lo | hi;
    endfunction

    always_comb begin
        for (int ti = 0; ti < N; ti++)
            for (int tj = 0; tj < N; tj++)
                tp[ti*N+tj] = tile(a1[4*ti +: 4], b1[4*tj +: 4], apx1 && (ti + tj < APX_TILES));
    end

    always_comb begin
        sum = '0;
        for (int ti = 0; ti < N; ti++)
            for (int tj = 0; tj < N; tj++)
                sum = sum + (PW'(t2[ti*N+tj]) << (4 * (ti + tj)));
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            v1        <= 1'b0;
            a1        <= '0;
            b1        <= '0;
            apx1      <= 1'b0;
            v2        <= 1'b0;
            t2        <= '{default: '0};
            out_valid <= 1'b0;
            out_p     <= '0;
        end else if (!stall) begin
            v1        <= in_valid;
            a1        <= in_a;
            b1        <= in_b;
            apx1      <= in_apx;
            v2        <= v1;
            t2        <= tp;
            out_valid <= v2;
            out_p     <= sum;
        end
    end

`ifdef APPROX_MULT_ERR_STAT_EN
    logic [PW-1:0] ex2, ex3, diff;
    logic [PW+16:0] sum_next;

    assign diff     = ex3 - out_p;
    // Extra top bit flags overflow of the accumulator for saturation.
    assign sum_next = {1'b0, err_sum} + (PW + 17)'(diff);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ex2     <= '0;
            ex3     <= '0;
            err_cnt <= '0;
            err_sum <= '0;
        end else begin
            if (!stall) begin
                ex2 <= PW'(a1) * PW'(b1);
                ex3 <= ex2;
            end
            if (stat_clr) begin
                err_cnt <= '0;
                err_sum <= '0;
            end else if (out_valid && out_ready) begin
                if (diff != '0 && err_cnt != '1) err_cnt <= err_cnt + 32'd1;
                err_sum <= sum_next[PW+16] ? '1 : sum_next[PW+15:0];
            end
        end
    end
`else
    logic unused_stat_clr;
    assign unused_stat_clr = stat_clr;
    assign err_cnt         = '0;
    assign err_sum         = '0;
`endif
endmodule

// File: doc/approx_mult_pipe.md
# approx_mult_pipe

Pipelined, width-parametrised unsigned multiplier built from 4x4 tiles. Each tile is exact or OR-compressed approximate, selected per transaction. Sits between operand producers and accumulate/MAC logic in the approximate-multiplier datapath, with valid/ready flow control on both sides.

## Interface
- WIDTH, 8 — operand width. Multiple of 4, range 4..16.
- APX_COLS, 2 — low columns of an approximate tile that use OR compression. Range 0..4; 0 makes tiles exact.
- APX_TILES, 1 — tile pair (ti,tj), with ti, tj = nibble indices of A and B, is approximate when ti+tj < APX_TILES. Range 0..2*WIDTH/4-1.
- clk  in  1  rising-edge clock.
- rst_n  in  1  asynchronous active-low reset.
- in_valid  in  1  operands valid.
- in_ready  out  1  block accepts operands this cycle.
- in_a, in_b  in  WIDTH  unsigned operands.
- in_apx  in  1  1 = approximate mode for this transaction, 0 = exact.
- out_valid  out  1  result valid.
- out_ready  in  1  consumer accepts result.
- out_p  out  2*WIDTH  product.
- stat_clr  in  1  synchronous clear of the error statistics.
- err_cnt  out  32  number of results that differ from exact, saturating.
- err_sum  out  2*WIDTH+16  accumulated (exact − result), saturating.

## Operation
- Tile product, with pp[i][j] = a[i]&b[j] and column c = i+j:
  - Approximate tile: bit c for c < APX_COLS is the OR of all pp in column c; no carries come out of these columns.
  - Columns c ≥ APX_COLS are summed exactly: Σ pp·2^(i+j).
  - The tile value is the sum of both parts.
  - Exact tile: the full exact product.
- Approximate tiles are used only when in_apx = 1 and the tile satisfies ti+tj < APX_TILES. Otherwise every tile is exact.
- out_p is the sum of each tile value shifted by 4·(ti+tj). Summation is full width and never overflows 2*WIDTH.
- Approximation only underestimates: result ≤ exact.
- Pipeline:
  - S1: register operands and in_apx.
  - S2: compute and register tile products.
  - S3: adder tree and output register.
- Flow control is a global stall. stall = out_valid & ~out_ready. in_ready = ~stall.
  - While stalled, all stages hold their contents.
  - Bubbles are not squeezed out.
- Transfer rules:
  - An input transfer occurs when in_valid & in_ready.
  - An output transfer occurs when out_valid & out_ready.
  - in_apx travels with its data through the pipeline.

## Timing
- Latency: 3 cycles from an accepted input to out_valid, with no stall.
- Throughput: 1 result per cycle while out_ready = 1.
- Reset values: out_valid = 0, out_p = 0, err_cnt = 0, err_sum = 0, all stage valids = 0.
  - in_ready = 1 during and after reset.
- Reset asserted mid-operation discards all in-flight transactions. No result for them ever appears.
- out_p and out_valid stay stable while out_valid & ~out_ready.
- A simultaneous input and output transfer while full is legal. The pipeline advances one step.
- in_ready depends combinationally on out_ready. This is the only combinational in-to-out path.

## Configuration
- Macro APPROX_MULT_ERR_STAT_EN.
- Defined:
  - An exact product is pipelined alongside the result.
  - On each output transfer, err_cnt increments if result ≠ exact.
  - On each output transfer, err_sum adds (exact − result).
  - Both counters saturate at all-ones.
  - stat_clr zeroes both counters on the next edge. If a counted output transfer happens in the same cycle, clear wins and the event is dropped.
  - Values update one cycle after the transfer.
- Undefined:
  - The statistics logic and exact shadow path are not built.
  - err_cnt and err_sum are tied to 0, and stat_clr is ignored.
  - Datapath timing is identical in both builds.

## Test plan
- WIDTH=8, APX_COLS=2, APX_TILES=1; a=0x03, b=0x03, apx=1 → out_p=0x0007 three cycles after accept. With apx=0 → 0x0009.
- Same parameters; a=0xFF, b=0xFF: apx=1 → 0xFDFF; apx=0 → 0xFE01. With the macro, err_cnt=1 and err_sum=2 after the first, unchanged after the second.
- Back-to-back stream of 8 inputs, out_ready held low for cycles 4–7 → in_ready=0 during the stall, out_p stable, all 8 results in order with none lost or duplicated.
- Assert rst_n=0 with 3 transactions in flight → out_valid=0 immediately. No stale result appears after release, and the first new input yields a result 3 cycles later.
- stat_clr in the same cycle as a mismatching output transfer → err_cnt=0, err_sum=0 next cycle.
- APX_COLS=0, or random operands with apx=0 for 1000 vectors at WIDTH=4, 8, 16 → out_p equals a*b exactly.
